// File: rtl/pwm_gen.sv
// pwm_gen: PWM waveform from an external counter, with period-aligned shadow compares and dead-time complementary outputs.
module pwm_gen #(
  parameter int CW  = 16,
  parameter int DTW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  count_val,
  input  logic [CW-1:0]  period,
  input  logic           upnotdown,
  input  logic           pwm_en,
  input  logic [1:0]     functions,
  input  logic [CW-1:0]  compare1,
  input  logic [CW-1:0]  compare2,
  input  logic [DTW-1:0] deadtime,
  output logic           pwm_out,
  output logic           pwm_h,
  output logic           pwm_l,
  output logic           period_start
);
  typedef enum logic [2:0] {OFF, LOW, DT_H, HIGH, DT_L} state_t;
  state_t state, nxt;
  logic [CW-1:0] prev_count, cmp1_sh, cmp2_sh;
  logic [1:0] func_sh;
  logic [DTW-1:0] dt_cnt, nxt_cnt, dt_load;
  logic wrap, raw;
  // A held or stopped counter never repeats its start value as a new boundary
  assign wrap = (count_val != prev_count) && (upnotdown ? count_val == '0 : count_val == period);
  assign raw = func_sh[1] ? (count_val >= cmp1_sh && count_val < cmp2_sh) :
               func_sh[0] ? count_val >= cmp1_sh : count_val < cmp1_sh;
  assign dt_load = deadtime - DTW'(1);
  always_comb begin
    nxt = state;
    nxt_cnt = dt_cnt;
    if (!pwm_en) nxt = OFF;
    else
      case (state)
        OFF, LOW: begin
          if (pwm_out) begin
            nxt = deadtime == '0 ? HIGH : DT_H;
            nxt_cnt = dt_load;
          end else nxt = LOW;
        end
        DT_H: begin
          if (!pwm_out) nxt = LOW;
          else if (dt_cnt == '0) nxt = HIGH;
          else nxt_cnt = dt_cnt - DTW'(1);
        end
        HIGH: begin
          if (!pwm_out) begin
            nxt = deadtime == '0 ? LOW : DT_L;
            nxt_cnt = dt_load;
          end
        end
        DT_L: begin
          if (pwm_out) nxt = HIGH;
          else if (dt_cnt == '0) nxt = LOW;
          else nxt_cnt = dt_cnt - DTW'(1);
        end
        default: nxt = OFF;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_count   <= '0;
      cmp1_sh      <= '0;
      cmp2_sh      <= '0;
      func_sh      <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      state        <= OFF;
      dt_cnt       <= '0;
      pwm_h        <= 1'b0;
      pwm_l        <= 1'b0;
    end else begin
      prev_count   <= count_val;
      period_start <= wrap;
      pwm_out      <= pwm_en & raw;
      if (wrap || !pwm_en) begin
        cmp1_sh <= compare1;
        cmp2_sh <= compare2;
        func_sh <= functions;
      end
      state  <= nxt;
      dt_cnt <= nxt_cnt;
      pwm_h  <= nxt == HIGH;
      pwm_l  <= nxt == LOW;
    end
  end
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: randomized scoreboard bench for pwm_gen against a run-length behavioural model.
module tb_pwm_gen;
  localparam int CW = 16, DTW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [CW-1:0] count_val = '0, period = 16'd9, compare1 = '0, compare2 = '0;
  logic upnotdown = 1'b1, pwm_en = 1'b0;
  logic [1:0] functions = '0;
  logic [DTW-1:0] deadtime = '0;
  logic pwm_out, pwm_h, pwm_l, period_start;
  pwm_gen #(.CW(CW), .DTW(DTW)) dut (
    .clk(clk), .rst(rst), .count_val(count_val), .period(period), .upnotdown(upnotdown),
    .pwm_en(pwm_en), .functions(functions), .compare1(compare1), .compare2(compare2),
    .deadtime(deadtime), .pwm_out(pwm_out), .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [3:0] v;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  bit freeze = 0;
  int hold_pct = 0;
  logic [CW-1:0] m_prev = '0, m_c1 = '0, m_c2 = '0;
  logic [1:0] m_f = '0;
  bit m_po = 0, runx = 0;
  int run = 0, rund = 0, last = 0;
  function automatic bit in_window(logic [CW-1:0] c, logic [CW-1:0] c1, logic [CW-1:0] c2, logic [1:0] f);
    if (f[1]) return c >= c1 && c < c2;
    if (f[0]) return c >= c1;
    return c < c1;
  endfunction
  // last: 0 = no side driven since enable, 1 = low side, 2 = high side
  task automatic model_push();
    logic [3:0] v;
    bit w, r, x, h, l;
    if (rst) begin
      m_prev = '0; m_c1 = '0; m_c2 = '0; m_f = '0; m_po = 0; run = 0; last = 0;
      v = '0;
    end else begin
      w = (count_val != m_prev) && (upnotdown ? count_val == '0 : count_val == period);
      r = in_window(count_val, m_c1, m_c2, m_f);
      x = m_po;
      h = 0; l = 0;
      if (!pwm_en) begin
        run = 0; last = 0;
      end else begin
        if (run == 0 || x != runx) begin
          run = 1; runx = x; rund = int'(deadtime);
        end else run++;
        h = x && (run > rund || last == 2);
        l = !x && (run > rund || last != 2);
        if (h) last = 2;
        if (l) last = 1;
      end
      if (w || !pwm_en) begin
        m_c1 = compare1; m_c2 = compare2; m_f = functions;
      end
      m_prev = count_val;
      m_po = pwm_en && r;
      v = {w, m_po, h, l};
    end
    q.push_back('{cyc, v});
    cyc++;
  endtask
  task automatic tick(int n);
    repeat (n) begin
      model_push();
      @(negedge clk);
      if (!freeze && $urandom_range(0, 99) >= hold_pct)
        count_val = upnotdown ? ((count_val >= period) ? '0 : count_val + 1'b1)
                              : ((count_val == '0) ? period : count_val - 1'b1);
    end
  endtask
  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        got = {period_start, pwm_out, pwm_h, pwm_l};
        tests++;
        if (got !== e.v) begin
          fails++;
          $display("FAIL outputs cyc %0d {ps,out,h,l} got %b expected %b", e.cyc, got, e.v);
        end
        tests++;
        if (pwm_h && pwm_l) begin
          fails++;
          $display("FAIL overlap cyc %0d pwm_h=%b pwm_l=%b expected not both 1", e.cyc, pwm_h, pwm_l);
        end
      end
    end
  end
  initial begin
    rst = 1; tick(3); rst = 0; tick(20);
    compare1 = 3; pwm_en = 1; tick(30);
    for (int i = 0; i < 40 && count_val != 5; i++) tick(1);
    compare1 = 7; tick(30);
    functions = 2'b10; compare1 = 2; compare2 = 6; tick(30);
    compare2 = 1; tick(30);
    functions = 2'b00; compare1 = 5; deadtime = 2; tick(40);
    for (int i = 0; i < 40 && count_val != 4; i++) tick(1);
    freeze = 1; tick(20);
    pwm_en = 0; compare1 = 8; tick(1);
    pwm_en = 1; freeze = 0; tick(20);
    rst = 1; tick(1); rst = 0; tick(20);
    hold_pct = 20;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        period = CW'($urandom_range(0, 15));
        upnotdown = 1'($urandom_range(0, 1));
        compare1 = ($urandom_range(0, 9) == 0) ? 16'hFFFF : CW'($urandom_range(0, 18));
        compare2 = CW'($urandom_range(0, 18));
        functions = 2'($urandom_range(0, 3));
        deadtime = DTW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 39) == 0) pwm_en = !pwm_en;
      rst = $urandom_range(0, 499) == 0;
      tick(1);
    end
    rst = 0; tick(5);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Consumer end of the PWM counter interface. Samples the counter's count_val/upnotdown/en each clock and generates the PWM waveform.
- Compare values and mode are held in shadow registers that update only at period boundaries, so a compare change never glitches an active period.
- Produces a raw PWM output plus a complementary high/low pair with programmable dead-time for the output stage.

Parameters:
- CW, 16, counter/compare width (matches count_val and period).
- DTW, 8, dead-time counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- count_val  input  CW  current counter value.
- period  input  CW  counter terminal value, same value the counter uses.
- upnotdown  input  1  counter direction: 1 = up, 0 = down.
- pwm_en  input  1  output enable.
- functions  input  2  mode: [1]=0 aligned, [1]=1 unaligned; [0]=0 left-aligned, [0]=1 right-aligned (ignored when unaligned).
- compare1  input  CW  first compare threshold.
- compare2  input  CW  second compare threshold (unaligned mode only).
- deadtime  input  DTW  dead-time length in clk cycles.
- pwm_out  output  1  raw PWM, registered.
- pwm_h  output  1  high-side drive.
- pwm_l  output  1  low-side drive, complement of pwm_h with dead-time.
- period_start  output  1  one-cycle pulse at each detected period boundary.

Behaviour:
- Reset: pwm_out=0, pwm_h=0, pwm_l=0, period_start=0, FSM=OFF, prev_count=0, shadow regs (cmp1_sh, cmp2_sh, func_sh)=0, dt_cnt=0.
- prev_count: registers count_val every cycle.
- Boundary detect:
  - wrap = (count_val != prev_count) && (upnotdown ? count_val==0 : count_val==period).
  - period_start is wrap registered: high one cycle, one clock after the counter shows its start value.
  - The counter's prescaler hold, en=0 and period=0 produce no boundary, because count_val does not change.
- Shadow load: cmp1_sh/cmp2_sh/func_sh load from the inputs on the cycle wrap=1, or on any cycle with pwm_en=0 (transparent while disabled). Otherwise they hold.
- Raw compare, combinational on current count_val and shadows:
  - Left-aligned: raw = count_val < cmp1_sh. cmp1_sh=0 gives constant 0; cmp1_sh>period gives constant 1.
  - Right-aligned: raw = count_val >= cmp1_sh. cmp1_sh=0 gives constant 1.
  - Unaligned: raw = (count_val >= cmp1_sh) && (count_val < cmp2_sh). If cmp2_sh <= cmp1_sh, raw=0.
  - Compares are unsigned, full CW width.
- pwm_out <= pwm_en ? raw : 0. Latency is 1 clk from count_val.
- Dead-time FSM, Moore outputs, registered from pwm_out:
  - OFF: h=0, l=0. If pwm_en=1, go to LOW when pwm_out=0, or to DT_H when pwm_out=1.
  - LOW: h=0, l=1. If pwm_out=1, go to DT_H, or to HIGH when deadtime=0.
  - DT_H: h=0, l=0, dt_cnt counts down. When the count expires and pwm_out=1, go to HIGH. If pwm_out=0 at any time here, go to LOW immediately.
  - HIGH: h=1, l=0. If pwm_out=0, go to DT_L, or to LOW when deadtime=0.
  - DT_L: h=0, l=0. Mirror of DT_H toward LOW. If pwm_out=1 at any time here, go to HIGH.
  - Dead-time length: both outputs are 0 for exactly deadtime cycles per transition. dt_cnt loads deadtime-1 on entry to a DT state.
  - pwm_en=0 in any state: go to OFF next cycle.
  - Latency: pwm_h/pwm_l change 2 clk after count_val, plus dead-time.
- Invariant: pwm_h && pwm_l is never 1, in any cycle, in any mode.
- Mid-operation rst: all state returns to reset values next edge, regardless of FSM state.
- deadtime change during a DT state takes effect on the next DT entry only.

Test Plan:
- Reset/boundary: rst for 3 cycles, then drive count_val 0..9 repeating (period=9, up, prescale 0) -> all outputs 0 during rst; period_start pulses once per 10 cycles, one clk after count_val=0.
- Left-aligned: compare1=3, functions=00, pwm_en=1, deadtime=0 -> pwm_out high 3 of 10 cycles (count 0,1,2, delayed 1 clk); pwm_h=pwm_out delayed 1 clk; pwm_l is its complement.
- Shadow update: change compare1 3->7 while count_val=5 -> pwm_out pattern unchanged until the next count_val=0, then high 7 of 10 cycles.
- Unaligned plus degenerate: functions=10, compare1=2, compare2=6 -> pwm_out high for count 2..5. Then compare2=1 -> pwm_out constant 0 after the next boundary.
- Dead-time: compare1=5, deadtime=2 -> on each pwm_out edge, both pwm_h and pwm_l are 0 for exactly 2 cycles; pwm_h high for 3 cycles per period; never both 1.
- Hold/disable: counter held (count_val constant 4 for 20 cycles) -> no period_start. Then pwm_en=0 for 1 cycle -> all outputs 0 the following cycle; shadows track the inputs while disabled.
